// File: rtl/multdiv_scheduler_pkg.sv
// Shared control constants for the mul/div scheduler: FSM encoding, ALU_op codes
// and the default exception destination/codes.
package multdiv_scheduler_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;
  localparam logic [1:0] ST_WB    = 2'd3;

  localparam logic [4:0] ALU_OP_MUL = 5'b00110;
  localparam logic [4:0] ALU_OP_DIV = 5'b00111;

  localparam logic [4:0]  RSTATUS_REG_DEF  = 5'd30;
  localparam logic [31:0] MUL_EXC_CODE_DEF = 32'd4;
  localparam logic [31:0] DIV_EXC_CODE_DEF = 32'd5;

endpackage

// File: rtl/multdiv_scheduler_if.sv
// Link between the scheduler (master) and the iterative mul/div unit (slave).
// Handshake: the master pulses md_ctrl_mult/md_ctrl_div for one cycle with md_a/md_b
// stable; the slave raises md_ready (with md_result/md_exception valid) for a cycle
// when done, and the master consumes it on that edge; md_a/md_b stay put until idle.
interface multdiv_scheduler_if;
  logic        md_ctrl_mult;
  logic        md_ctrl_div;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_ready;

  modport master (
    output md_ctrl_mult, md_ctrl_div, md_a, md_b,
    input  md_result, md_exception, md_ready
  );

  modport slave (
    input  md_ctrl_mult, md_ctrl_div, md_a, md_b,
    output md_result, md_exception, md_ready
  );
endinterface

// File: rtl/multdiv_scheduler_md_hazard_cmp.sv
// RAW compare of the two D-stage sources against one in-flight destination;
// r0 never creates a hazard since it is never written.
module md_hazard_cmp (
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic [4:0] rd,
    output logic       hit
);
    assign hit = (rd != 5'd0) && ((rs == rd) || (rt == rd));
endmodule

// File: rtl/multdiv_scheduler.sv
// Sequences the shared iterative mul/div unit beside X: latch, start pulse, wait,
// single writeback (to $rstatus on exception/timeout), stalling dependents meanwhile.
module multdiv_scheduler
  import multdiv_scheduler_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 40,
    parameter logic [4:0]  RSTATUS_REG    = RSTATUS_REG_DEF,
    parameter logic [31:0] MUL_EXC_CODE   = MUL_EXC_CODE_DEF,
    parameter logic [31:0] DIV_EXC_CODE   = DIV_EXC_CODE_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       ex_valid,
    input  logic                       ex_mul,
    input  logic                       ex_div,
    input  logic [4:0]                 ex_rd,
    input  logic [31:0]                ex_a,
    input  logic [31:0]                ex_b,
    input  logic                       dec_valid,
    input  logic [4:0]                 dec_rs,
    input  logic [4:0]                 dec_rt,
    input  logic                       flush,
    multdiv_scheduler_if.master        md,
    output logic                       stall,
    output logic                       busy,
    output logic                       wb_valid,
    output logic [4:0]                 wb_rd,
    output logic [31:0]                wb_data,
    output logic                       timeout_err,
    output logic [1:0]                 dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]       state;
    logic [4:0]       busy_rd;
    logic             op_is_div;
    logic             exc_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   cnt_inc;
    logic             timeout_hit;
    logic             issue;
    logic             md_op_in_x;
    logic [4:0]       cmp_rd;
    logic             raw_hit;

    assign md_op_in_x  = ex_valid && (ex_mul || ex_div);
    assign issue       = (state == ST_IDLE) && md_op_in_x && !flush;
    assign cnt_inc     = {1'b0, cnt} + (CNT_W + 1)'(1);
    assign timeout_hit = cnt_inc >= (CNT_W + 1)'(TIMEOUT_CYCLES);

    // Once an exception writeback is pending, dependents must wait on $rstatus, not rd.
    assign cmp_rd = ((state == ST_WB) && exc_q) ? RSTATUS_REG : busy_rd;

    md_hazard_cmp u_hazard_cmp (
        .rs  (dec_rs),
        .rt  (dec_rt),
        .rd  (cmp_rd),
        .hit (raw_hit)
    );

    assign busy      = (state != ST_IDLE);
    assign stall     = busy && (md_op_in_x || (dec_valid && raw_hit));
    assign dbg_state = state;

    assign md.md_ctrl_mult = (state == ST_START) && !op_is_div;
    assign md.md_ctrl_div  = (state == ST_START) && op_is_div;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            md.md_a     <= '0;
            md.md_b     <= '0;
            busy_rd     <= '0;
            op_is_div   <= 1'b0;
            exc_q       <= 1'b0;
            cnt         <= '0;
            timeout_err <= 1'b0;
            wb_valid    <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        state     <= ST_START;
                        md.md_a   <= ex_a;
                        md.md_b   <= ex_b;
                        busy_rd   <= ex_rd;
                        op_is_div <= !ex_mul;
                    end
                end
                ST_START: begin
                    state <= ST_BUSY;
                    cnt   <= '0;
                end
                ST_BUSY: begin
                    cnt <= (cnt == {CNT_W{1'b1}}) ? cnt : cnt_inc[CNT_W-1:0];
                    if (md.md_ready || timeout_hit) begin
                        // Ready wins over a coincident timeout.
                        state <= ST_WB;
                        exc_q <= md.md_ready ? md.md_exception : 1'b1;
                        if (!md.md_ready) timeout_err <= 1'b1;
                        if (!md.md_ready || md.md_exception) begin
                            wb_valid <= 1'b1;
                            wb_rd    <= RSTATUS_REG;
                            wb_data  <= op_is_div ? DIV_EXC_CODE : MUL_EXC_CODE;
                        end else begin
                            wb_valid <= (busy_rd != 5'd0);
                            wb_rd    <= busy_rd;
                            wb_data  <= md.md_result;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    exc_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/multdiv_scheduler.md
# multdiv_scheduler

Sequencer that sits beside the execute stage and runs the shared iterative multiplier/divider for `mul`/`div` R-type ops (ALU_op 00110/00111). It latches operands and destination, pulses the unit's start controls and waits for its ready flag. It stalls dependent instructions while the op is in flight, then issues one writeback. On overflow or divide-by-zero, that writeback goes to $rstatus (r30) instead of rd.

## Interface
- `TIMEOUT_CYCLES`, default 40: BUSY cycles allowed before the op is forced to an exception.
- `RSTATUS_REG`, default 5'd30: exception destination register.
- `MUL_EXC_CODE`, default 32'd4: $rstatus value written on a mul exception.
- `DIV_EXC_CODE`, default 32'd5: $rstatus value written on a div exception.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ex_valid`  in  1  instruction in X stage is valid.
- `ex_mul`, `ex_div`  in  1  X-stage op decodes as mul / div.
- `ex_rd`  in  5  X-stage destination register.
- `ex_a`, `ex_b`  in  32  X-stage operands (rs, rt values).
- `dec_valid`  in  1  instruction in D stage is valid.
- `dec_rs`, `dec_rt`  in  5  D-stage source registers.
- `flush`  in  1  branch/jump squash of the X-stage instruction.
- `md_ctrl_mult`, `md_ctrl_div`  out  1  one-cycle start pulses to the unit.
- `md_a`, `md_b`  out  32  latched operands, held stable from START until IDLE.
- `md_result`  in  32  unit result.
- `md_exception`  in  1  unit overflow / divide-by-zero flag.
- `md_ready`  in  1  unit result valid.
- `stall`  out  1  freeze PC, F/D and D/X, and bubble X.
- `busy`  out  1  state is not IDLE.
- `wb_valid`  out  1  regfile write request; it has priority over the pipeline writeback that cycle.
- `wb_rd`  out  5  write address.
- `wb_data`  out  32  write data.
- `timeout_err`  out  1  sticky; set on timeout, cleared only by reset.

## Operation
FSM states are IDLE, START, BUSY and WB.
- **IDLE to START.** Taken when `ex_valid & (ex_mul|ex_div) & !flush`.
  - Latches `ex_a`/`ex_b` into `md_a`/`md_b` and `ex_rd` into `busy_rd`.
  - Latches `op_is_div = !ex_mul`. mul wins if both flags are set.
- **START to BUSY.** START lasts one cycle. It asserts `md_ctrl_mult` or `md_ctrl_div` and clears the cycle counter. `md_ready` is ignored in START.
- **BUSY to WB.** Taken on `md_ready`. Latches `md_result` and `md_exception`.
  - The counter increments every BUSY cycle.
  - If the count reaches TIMEOUT_CYCLES without ready, go to WB with the exception forced to 1 and set `timeout_err`.
- **WB to IDLE.** WB lasts one cycle.
  - Exception case: `wb_valid=1`, `wb_rd=RSTATUS_REG`, `wb_data` = MUL_EXC_CODE or DIV_EXC_CODE.
  - Normal case: `wb_rd=busy_rd`, `wb_data` = latched result, and `wb_valid = (busy_rd!=0)`.
- **stall** is asserted combinationally when state is not IDLE and either condition holds:
  - `ex_valid & (ex_mul|ex_div)`: a second md op waits.
  - `dec_valid` and `busy_rd!=0` and `dec_rs==busy_rd` or `dec_rt==busy_rd`: RAW hazard. The comparison uses RSTATUS_REG instead of `busy_rd` while in WB with an exception.
- **stall in WB.** stall still applies in WB. It drops in the cycle after WB, when the written value is readable through regfile write-through.
- **flush.** flush outside IDLE does not cancel: the md op has already left X. flush in IDLE blocks issue that cycle.
- **Counter width.** $clog2(TIMEOUT_CYCLES+1) bits, saturating.
- **Reset.** Asynchronous, any state. State goes to IDLE; all outputs go to 0, including `md_a`, `md_b`, `busy_rd` and the counter. An in-flight op is dropped and its writeback never issues.

## Timing
- **Issue.** Issue sampled at edge N puts START in cycle N+1, where the ctrl pulse is high for exactly one cycle. BUSY starts at N+2.
- **Latency.** `md_ready` sampled at edge M gives `wb_valid` in cycle M+1. Minimum issue-to-writeback is 3 cycles.
- **Back-to-back ops.** A stalled md op issues on the first edge after WB, so it enters START 2 cycles after WB.
- **Early ready.** A `md_ready` already high at BUSY entry completes on the first BUSY cycle.
- **Output timing.** `stall` and `busy` are combinational from state and registers. The `wb_*` outputs are registered.

## Structure
- Shared control package:
  - FSM state encoding.
  - ALU_op codes MUL=5'b00110 and DIV=5'b00111.
  - RSTATUS_REG and the exception codes.
- One sub-module, `md_hazard_cmp`: a 5-bit dual compare with the r0 mask. The FSM and counter stay in the top module.

## Test plan
- **mul, normal.** mul rd=3, a=6, b=7, ready 33 cycles after START, result 42. Expect one `md_ctrl_mult` pulse, then `wb_valid` with rd=3, data=42, exactly once. No timeout.
- **div by zero.** div rd=4, a=10, b=0, ready with exception. Expect `wb_rd`=30, `wb_data`=5. Register 4 is not written.
- **RAW hazard.** Dependent add (rs=3) in D during a mul to r3. Expect `stall` high from START through WB and low the following cycle. An independent instruction (rs=5, rt=6) is not stalled.
- **Back-to-back, r0, flush.**
  - A second mul in X while busy stalls and then issues after WB.
  - A mul to r0 produces no `wb_valid`.
  - flush in the issue cycle produces no START.
- **Timeout.** `md_ready` never asserted. Expect WB after 40 BUSY cycles with `wb_rd`=30 and `wb_data`=4, and `timeout_err` set until reset.
- **Reset mid-op.** reset pulled low in BUSY. Expect an immediate return to IDLE with all outputs 0. A later `md_ready` pulse is ignored.
